// File: rtl/spike_readout_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spike_readout_ctrl: Avalon-MM master that drains detector spike windows   |
// | into a valid/ready sample stream.                     Revision: 1.0      |
// +--------------------------------------------------------------------------+
module spike_readout_ctrl #(
  parameter int          WIN_LEN  = 150,
  parameter logic [13:0] WIN_BASE = 14'h1000
) (
  input  logic        avl_clk_i,
  input  logic        avl_reset_i,
  input  logic        start_i,
  input  logic        stop_i,
  output logic [13:0] avl_m_address_o,
  output logic        avl_m_write_o,
  output logic [15:0] avl_m_writedata_o,
  output logic        avl_m_read_o,
  input  logic [15:0] avl_m_readdata_i,
  input  logic        avl_m_readdatavalid_i,
  input  logic        avl_m_waitrequest_i,
  input  logic        avl_irq_i,
  output logic [15:0] spk_data_o,
  output logic        spk_valid_o,
  input  logic        spk_ready_i,
  output logic        spk_last_o,
  output logic        busy_o,
  output logic [15:0] win_count_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_START  = 3'd1,
    S_WAIT_IRQ  = 3'd2,
    S_RD_STATUS = 3'd3,
    S_RD_SAMPLE = 3'd4,
    S_PUSH      = 3'd5,
    S_WR_ACK    = 3'd6,
    S_WR_STOP   = 3'd7
  } state_t;

  localparam logic [9:0]  LAST_IDX    = 10'(WIN_LEN - 1);
  localparam logic [13:0] ADDR_STATUS = 14'd0;
  localparam logic [13:0] ADDR_CTRL   = 14'd1;
  localparam logic [13:0] ADDR_ACK    = 14'd2;

  state_t      state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic [15:0] data_q, data_d;
  logic [9:0]  idx_q, idx_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        stop_q, stop_d;

  logic wr_done;
  logic rd_accept;
  logic rd_data;

  assign wr_done   = write_q & ~avl_m_waitrequest_i;
  assign rd_accept = read_q & ~avl_m_waitrequest_i;
  // Read data is only meaningful once the request has been accepted.
  assign rd_data   = ~read_q & avl_m_readdatavalid_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    read_d  = read_q;
    data_d  = data_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    stop_d  = stop_q | (stop_i & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (start_i) begin
          state_d = S_WR_START;
          wcnt_d  = 16'd0;
          idx_d   = 10'd0;
          stop_d  = stop_i;
        end
      end
      S_WR_START: begin
        // Write states raise their own request so consecutive writes are
        // always separated by a deasserted cycle.
        if (!write_q) begin
          write_d = 1'b1;
          addr_d  = ADDR_CTRL;
          wdata_d = 16'd1;
        end else if (wr_done) begin
          write_d = 1'b0;
          state_d = S_WAIT_IRQ;
        end
      end
      S_WAIT_IRQ: begin
        if (avl_irq_i) begin
          state_d = S_RD_STATUS;
          read_d  = 1'b1;
          addr_d  = ADDR_STATUS;
        end else if (stop_q) begin
          state_d = S_WR_STOP;
        end
      end
      S_RD_STATUS: begin
        if (read_q) begin
          if (rd_accept) read_d = 1'b0;
        end else if (rd_data) begin
          if (avl_m_readdata_i[0]) begin
            state_d = S_RD_SAMPLE;
            idx_d   = 10'd0;
            read_d  = 1'b1;
            addr_d  = WIN_BASE;
          end else begin
            state_d = S_WR_ACK;
          end
        end
      end
      S_RD_SAMPLE: begin
        if (read_q) begin
          if (rd_accept) read_d = 1'b0;
        end else if (rd_data) begin
          state_d = S_PUSH;
          data_d  = avl_m_readdata_i;
        end
      end
      S_PUSH: begin
        if (spk_ready_i) begin
          if (idx_q != LAST_IDX) begin
            state_d = S_RD_SAMPLE;
            idx_d   = idx_q + 10'd1;
            read_d  = 1'b1;
            addr_d  = WIN_BASE + 14'(idx_q) + 14'd1;
          end else begin
            state_d = S_WR_ACK;
            wcnt_d  = wcnt_q + 16'd1;
          end
        end
      end
      S_WR_ACK: begin
        if (!write_q) begin
          write_d = 1'b1;
          addr_d  = ADDR_ACK;
          wdata_d = 16'd1;
        end else if (wr_done) begin
          write_d = 1'b0;
          state_d = (stop_q | stop_i) ? S_WR_STOP : S_WAIT_IRQ;
        end
      end
      S_WR_STOP: begin
        if (!write_q) begin
          write_d = 1'b1;
          addr_d  = ADDR_CTRL;
          wdata_d = 16'd0;
        end else if (wr_done) begin
          write_d = 1'b0;
          state_d = S_IDLE;
          stop_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge avl_clk_i or posedge avl_reset_i) begin
    if (avl_reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= 14'd0;
      wdata_q <= 16'd0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      data_q  <= 16'd0;
      idx_q   <= 10'd0;
      wcnt_q  <= 16'd0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      read_q  <= read_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      stop_q  <= stop_d;
    end
  end

  assign avl_m_address_o   = addr_q;
  assign avl_m_write_o     = write_q;
  assign avl_m_writedata_o = wdata_q;
  assign avl_m_read_o      = read_q;
  assign spk_data_o        = data_q;
  assign spk_valid_o       = (state_q == S_PUSH);
  assign spk_last_o        = (state_q == S_PUSH) && (idx_q == LAST_IDX);
  assign busy_o            = (state_q != S_IDLE);
  assign win_count_o       = wcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_readout_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spike_readout_ctrl: detector/sink model with transaction scoreboard.   |
// |                                                       Revision: 1.0      |
// +--------------------------------------------------------------------------+
module tb_spike_readout_ctrl;

  localparam int          WL   = 4;
  localparam logic [13:0] WB   = 14'h1000;
  localparam logic [13:0] WEND = WB + 14'(WL);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [13:0] addr;
  logic        wr, rd;
  logic [15:0] wdata;
  logic [15:0] rdata = 16'd0;
  logic        rvalid = 1'b0;
  logic        waitreq = 1'b0;
  logic        irq = 1'b0;
  logic [15:0] spk_data;
  logic        spk_valid, spk_last, busy;
  logic        spk_ready = 1'b0;
  logic [15:0] wcnt;

  spike_readout_ctrl #(.WIN_LEN(WL), .WIN_BASE(WB)) dut (
    .avl_clk_i            (clk),
    .avl_reset_i          (rst),
    .start_i              (start),
    .stop_i               (stop),
    .avl_m_address_o      (addr),
    .avl_m_write_o        (wr),
    .avl_m_writedata_o    (wdata),
    .avl_m_read_o         (rd),
    .avl_m_readdata_i     (rdata),
    .avl_m_readdatavalid_i(rvalid),
    .avl_m_waitrequest_i  (waitreq),
    .avl_irq_i            (irq),
    .spk_data_o           (spk_data),
    .spk_valid_o          (spk_valid),
    .spk_ready_i          (spk_ready),
    .spk_last_o           (spk_last),
    .busy_o               (busy),
    .win_count_o          (wcnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Expected bus operations and samples, in the order the detector must see them.
  typedef struct {
    bit          w;
    logic [13:0] a;
    logic [15:0] d;
  } bus_t;
  bus_t        exp_bus[$];
  logic [16:0] exp_samp[$];

  int          wmode = 0;   // 0 no stall, 1 random stall, 2 three-cycle stall
  int          rmode = 0;   // 0 ready high, 1 toggling, 2 random
  int          ws_left = -1;
  int          rsp_cnt = 0;
  logic [15:0] rsp_data = 16'd0;
  logic [15:0] mem [WL];
  bit          status_bit = 1'b0;
  int          hs_count = 0;
  bit          ready_tog = 1'b0;
  logic [13:0] last_rd_addr = 14'd0;
  bit          stalled = 1'b0;
  logic [31:0] held_bus = 32'd0;
  bit          held = 1'b0;
  logic [16:0] held_spk = 17'd0;
  int          model_wc = 0;

  always @(negedge clk) begin
    if (rst) begin
      waitreq   = 1'b0;
      rvalid    = 1'b0;
      rdata     = 16'd0;
      ws_left   = -1;
      rsp_cnt   = 0;
      stalled   = 1'b0;
      held      = 1'b0;
      spk_ready = 1'b0;
    end else begin
      rvalid = 1'b0;
      rdata  = 16'($urandom);
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rvalid = 1'b1;
          rdata  = rsp_data;
        end
      end

      case (rmode)
        0:       spk_ready = 1'b1;
        1: begin ready_tog = !ready_tog; spk_ready = ready_tog; end
        default: spk_ready = 1'($urandom_range(0, 1));
      endcase

      if (stalled) chk("bus_hold", {wr, rd, addr, wdata}, held_bus);
      if (held)    chk("spk_hold", 32'({spk_valid, spk_data}), 32'(held_spk));
      chk("no_req_while_valid", 32'(spk_valid & (rd | wr)), 32'd0);
      chk("rd_wr_exclusive", 32'(rd & wr), 32'd0);
      if (rd | wr) chk("busy_during_req", 32'(busy), 32'd1);
      if (rd)      chk("one_outstanding", 32'(rsp_cnt != 0), 32'd0);
      if (!spk_valid) chk("last_without_valid", 32'(spk_last), 32'd0);

      if (rd | wr) begin
        if (ws_left < 0)
          ws_left = (wmode == 2) ? 3 : (wmode == 1) ? int'($urandom_range(0, 3)) : 0;
        waitreq = (ws_left > 0);
        if (ws_left > 0) ws_left--;
      end else begin
        waitreq = 1'b0;
      end
      stalled  = (rd | wr) & waitreq;
      held_bus = {wr, rd, addr, wdata};

      if ((rd | wr) && !waitreq) begin
        ws_left = -1;
        if (exp_bus.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_bus: actual wr=%0d rd=%0d addr=0x%0h data=0x%0h required none",
                   wr, rd, addr, wdata);
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          chk("bus_type", 32'({wr, rd}), e.w ? 32'd2 : 32'd1);
          chk("bus_addr", 32'(addr), 32'(e.a));
          if (e.w) chk("bus_wdata", 32'(wdata), 32'(e.d));
        end
        if (rd) begin
          last_rd_addr = addr;
          if (addr == 14'd0)                  rsp_data = {15'($urandom), status_bit};
          else if (addr >= WB && addr < WEND) rsp_data = mem[int'(addr - WB)];
          else                                rsp_data = 16'($urandom);
          rsp_cnt = int'($urandom_range(1, 3));
        end
        if (wr && addr == 14'd2 && wdata == 16'd1) irq = 1'b0;
      end

      held     = spk_valid & ~spk_ready;
      held_spk = {spk_valid, spk_data};
      if (spk_valid && spk_ready) begin
        hs_count++;
        if (exp_samp.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_sample: actual 0x%0h required none", spk_data);
        end else begin
          logic [16:0] s;
          s = exp_samp.pop_front();
          chk("spk_data", 32'(spk_data), 32'(s[15:0]));
          chk("spk_last", 32'(spk_last), 32'(s[16]));
        end
      end
    end
  end

  task automatic push_w(input logic [13:0] a, input logic [15:0] d);
    bus_t e;
    e.w = 1'b1; e.a = a; e.d = d;
    exp_bus.push_back(e);
  endtask

  task automatic push_r(input logic [13:0] a);
    bus_t e;
    e.w = 1'b0; e.a = a; e.d = 16'd0;
    exp_bus.push_back(e);
  endtask

  // A detector window: status read, WL sample reads if ready, then the ack.
  task automatic window(input bit st);
    status_bit = st;
    push_r(14'd0);
    if (st) begin
      for (int i = 0; i < WL; i++) begin
        mem[i] = 16'($urandom);
        push_r(WB + 14'(i));
        exp_samp.push_back({(i == WL - 1), mem[i]});
      end
      model_wc++;
    end
    push_w(14'd2, 16'd1);
    irq = 1'b1;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      done = (exp_bus.size() == 0) && (exp_samp.size() == 0) && (rsp_cnt == 0);
    end
    if (!done) begin
      fail_now({"drain_timeout_", name});
      exp_bus.delete();
      exp_samp.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse(input bit s, input bit p);
    @(negedge clk);
    start = s;
    stop  = p;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_bus", {wr, rd, addr, wdata}, 32'd0);
    chk("rst_spk", 32'({spk_valid, spk_last, busy, spk_data}), 32'd0);
    chk("rst_wcnt", 32'(wcnt), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Start: one control write, then silence until irq.
    model_wc = 0;
    push_w(14'd1, 16'd1);
    pulse(1'b1, 1'b0);
    drain("start");
    repeat (10) @(negedge clk);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("wcnt_after_start", 32'(wcnt), 32'd0);

    window(1'b1);
    drain("win1");
    chk("wcnt_lit_1", 32'(wcnt), 32'd1);
    chk("last_sample_addr", 32'(last_rd_addr), 32'h1003);

    wmode = 2; rmode = 1;
    window(1'b1);
    drain("win_stall");
    chk("wcnt_lit_2", 32'(wcnt), 32'd2);

    wmode = 1; rmode = 2;
    window(1'b0);
    drain("spurious");
    chk("wcnt_spurious", 32'(wcnt), 32'd2);

    for (int k = 0; k < 12; k++) begin
      wmode = int'($urandom_range(0, 2));
      rmode = int'($urandom_range(0, 2));
      window($urandom_range(0, 3) != 0);
      drain("rand");
      chk("wcnt_rand", 32'(wcnt), 32'(model_wc));
      chk("busy_rand", 32'(busy), 32'd1);
    end

    // start while busy is ignored (no extra write, count kept)
    pulse(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("wcnt_start_ignored", 32'(wcnt), 32'(model_wc));

    // stop during the second sample: window completes, ack, stop write
    begin
      int h0;
      bit got;
      h0 = hs_count;
      got = 1'b0;
      wmode = 1; rmode = 2;
      window(1'b1);
      push_w(14'd1, 16'd0);
      for (int c = 0; c < 1000 && !got; c++) begin
        @(negedge clk);
        got = (hs_count >= h0 + 1);
      end
      if (!got) fail_now("wait_sample2_timeout");
      pulse(1'b0, 1'b1);
      drain("stop_mid");
      chk("busy_after_stop", 32'(busy), 32'd0);
      chk("wcnt_after_stop", 32'(wcnt), 32'(model_wc));
    end

    pulse(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("busy_stop_idle", 32'(busy), 32'd0);

    // start and stop together: start wins, then immediate stop
    model_wc = 0;
    push_w(14'd1, 16'd1);
    push_w(14'd1, 16'd0);
    pulse(1'b1, 1'b1);
    drain("start_stop");
    chk("busy_start_stop", 32'(busy), 32'd0);
    chk("wcnt_start_stop", 32'(wcnt), 32'd0);

    // reset while a sample read is in flight
    model_wc = 0;
    wmode = 2; rmode = 0;
    push_w(14'd1, 16'd1);
    pulse(1'b1, 1'b0);
    drain("start2");
    window(1'b1);
    drain("win_pre_rst");
    chk("wcnt_pre_rst", 32'(wcnt), 32'd1);
    begin
      bit got;
      got = 1'b0;
      window(1'b1);
      for (int c = 0; c < 1000 && !got; c++) begin
        @(negedge clk);
        got = rd && (addr >= WB + 14'd1) && (addr < WEND);
      end
      if (!got) fail_now("wait_rd_sample_timeout");
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_bus", {wr, rd, addr, wdata}, 32'd0);
      chk("rst_mid_spk", 32'({spk_valid, spk_last, busy, spk_data}), 32'd0);
      chk("rst_mid_wcnt", 32'(wcnt), 32'd0);
      exp_bus.delete();
      exp_samp.delete();
      irq = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("busy_after_rst", 32'(busy), 32'd0);
    end

    model_wc = 0;
    push_w(14'd1, 16'd1);
    pulse(1'b1, 1'b0);
    drain("restart");
    window(1'b1);
    drain("win_restart");
    chk("wcnt_restart", 32'(wcnt), 32'd1);
    push_w(14'd1, 16'd0);
    pulse(1'b0, 1'b1);
    drain("final_stop");
    chk("busy_final", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_readout_ctrl.md
SPIKE_READOUT_CTRL -- requirements
Module: spike_readout_ctrl

Interface
REQ-001 SHALL have parameter WIN_LEN, default 150, meaning samples read per detected spike window (1..1023).
REQ-002 SHALL have parameter WIN_BASE, default 14'h1000, meaning Avalon word address of window sample 0 in the detector.
REQ-003 SHALL have ports:
  avl_clk_i  in  1  single clock, all logic on rising edge
  avl_reset_i  in  1  asynchronous, active-high reset
  start_i  in  1  one-cycle pulse, begin acquisition
  stop_i  in  1  one-cycle pulse, end acquisition
  avl_m_address_o  out  14  master word address
  avl_m_write_o  out  1  write request
  avl_m_writedata_o  out  16  write data
  avl_m_read_o  out  1  read request
  avl_m_readdata_i  in  16  read data
  avl_m_readdatavalid_i  in  1  read data valid
  avl_m_waitrequest_i  in  1  slave stall
  avl_irq_i  in  1  detector interrupt, level
  spk_data_o  out  16  window sample
  spk_valid_o  out  1  sample valid
  spk_ready_i  in  1  sink ready
  spk_last_o  out  1  last sample of window
  busy_o  out  1  acquisition active
  win_count_o  out  16  windows delivered since start

Function
REQ-004 SHALL use detector map: addr 0 status (bit0 = window ready), addr 1 control (write 1 start, 0 stop), addr 2 IRQ ack (write 1), WIN_BASE+i sample i.
REQ-005 SHALL implement FSM states IDLE, WR_START, WAIT_IRQ, RD_STATUS, RD_SAMPLE, PUSH, WR_ACK, WR_STOP.
REQ-006 IDLE: start_i -> WR_START; win_count_o cleared to 0 on start_i.
REQ-007 Master write: address/data/write held stable until a cycle with avl_m_waitrequest_i=0; write deasserted next cycle.
REQ-008 Master read: address/read held until waitrequest=0; read deasserted next cycle; data captured only on avl_m_readdatavalid_i=1; at most one read outstanding.
REQ-009 WR_START writes 1 to addr 1, then -> WAIT_IRQ; busy_o=1 from WR_START until WR_STOP write accepted.
REQ-010 WAIT_IRQ: avl_irq_i=1 -> RD_STATUS; stop pending -> WR_STOP.
REQ-011 RD_STATUS: bit0=1 -> RD_SAMPLE with index 0; bit0=0 (spurious) -> WR_ACK.
REQ-012 RD_SAMPLE reads WIN_BASE+index; on readdatavalid -> PUSH with sample in output register.
REQ-013 PUSH: spk_valid_o=1, data held stable until spk_valid_o & spk_ready_i; spk_last_o=1 only when index=WIN_LEN-1.
REQ-014 On handshake: index<WIN_LEN-1 -> index+1, RD_SAMPLE; else win_count_o+1 (wraps 0xFFFF->0), -> WR_ACK.
REQ-015 WR_ACK writes 1 to addr 2, then -> WR_STOP if stop pending, else WAIT_IRQ.
REQ-016 WR_STOP writes 0 to addr 1, then -> IDLE, stop pending cleared.
REQ-017 stop_i in any non-IDLE state SHALL set stop pending; a window in progress completes fully (all WIN_LEN samples and ack) before WR_STOP.
REQ-018 start_i while not IDLE and stop_i while IDLE SHALL be ignored; start_i and stop_i same cycle in IDLE: start wins, stop pending set.
REQ-019 No new read/write issued while spk_valid_o=1; sink backpressure of any length SHALL not lose or duplicate samples.

Reset
REQ-020 avl_reset_i=1 SHALL asynchronously force IDLE; all outputs 0 (address, writedata, spk_data_o, win_count_o included); stop pending and index cleared.
REQ-021 Reset mid-transaction SHALL abandon it; after release no master request until next start_i.

Verification
REQ-022 start_i, slave waitrequest=0 -> one write addr 1 data 1, busy_o=1, no further bus activity until irq.
REQ-023 irq=1, status=1, WIN_LEN=4, ready=1 -> reads 0x1000..0x1003 in order, 4 valids, spk_last_o on 4th, write addr 2 data 1, win_count_o=1.
REQ-024 waitrequest held 3 cycles per access and ready toggling 1/0 -> identical sample sequence, each sample exactly once, data stable while valid & !ready.
REQ-025 stop_i during sample 2 of 4 -> remaining samples delivered, ack write, write addr 1 data 0, busy_o=0, IDLE.
REQ-026 irq with status=0 -> ack write only, no sample reads, win_count_o unchanged.
REQ-027 reset asserted during RD_SAMPLE -> all outputs 0 same cycle, no bus requests after release until start_i.
